// File: rtl/alu_wide_seq_pkg.sv
// Shared types and constants for the wide-operand ALU sequencer.
// Enumerates the controller states and the add-class ALU select codes.
package alu_wide_seq_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Selects for which the ALU produces a meaningful carry chain
    localparam logic [3:0] SEL_ADD_0101 = 4'b0101;
    localparam logic [3:0] SEL_ADD_1000 = 4'b1000;
    localparam logic [3:0] SEL_ADD_1001 = 4'b1001;
    localparam logic [3:0] SEL_ADD_1010 = 4'b1010;
    localparam logic [3:0] SEL_ADD_1100 = 4'b1100;
    localparam logic [3:0] SEL_ADD_1101 = 4'b1101;
    localparam logic [3:0] SEL_ADD_1110 = 4'b1110;

endpackage

// File: rtl/alu_wide_seq.sv
// Issues a WORDS x 16-bit operation to an external 16-bit ALU one word per cycle,
// LSW first, chaining carry. Optional counters enabled by ALU_WIDE_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | ready for a request, ALU ports hold last values
// ISSUE | r_idx 1..WORDS: word r_idx-1 is on the ALU and gets stored
// DONE  | response presented until rsp_ready
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int WORDS = 2
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [WORD_W*WORDS-1:0] req_a,
    input  logic [WORD_W*WORDS-1:0] req_b,
    input  logic [3:0]              req_select,
    input  logic                    req_mode,
    input  logic                    req_carry_in,
    output logic [WORD_W-1:0]       alu_a,
    output logic [WORD_W-1:0]       alu_b,
    output logic [3:0]              alu_select,
    output logic                    alu_mode,
    output logic                    alu_carry_in,
    input  logic [WORD_W-1:0]       alu_out,
    input  logic                    alu_carry_out,
    input  logic                    alu_compare,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WORD_W*WORDS-1:0] rsp_result,
    output logic                    rsp_carry,
    output logic                    rsp_equal
`ifdef ALU_WIDE_SEQ_STATS_EN
   ,output logic [31:0]             stat_ops,
    output logic [31:0]             stat_carries
`endif
);

    localparam int OP_W  = WORD_W * WORDS;
    localparam int IDX_W = $clog2(WORDS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic [OP_W-1:0]   r_result;
    logic              r_carry;
    logic              r_eq;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_carry;
    logic              r_rsp_equal;
    logic [WORD_W-1:0] r_alu_a;
    logic [WORD_W-1:0] r_alu_b;
    logic [3:0]        r_alu_select;
    logic              r_alu_mode;
    logic              r_alu_carry_in;

    logic w_store;
    logic w_load;
    logic w_chain;

    // Index 0 is the priming cycle: nothing valid on the ALU yet
    assign w_store = (r_idx != '0);
    assign w_load  = (r_idx != IDX_LAST);
    assign w_chain = w_store ? alu_carry_out : r_carry;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_carry        <= 1'b0;
            r_eq           <= 1'b0;
            r_req_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_carry    <= 1'b0;
            r_rsp_equal    <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_select   <= '0;
            r_alu_mode     <= 1'b0;
            r_alu_carry_in <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_a          <= req_a;
                        r_b          <= req_b;
                        r_alu_select <= req_select;
                        r_alu_mode   <= req_mode;
                        r_carry      <= req_carry_in;
                        r_eq         <= 1'b1;
                        r_idx        <= '0;
                        r_req_ready  <= 1'b0;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_store) begin
                        r_result <= {alu_out, r_result[OP_W-1:WORD_W]};
                        r_carry  <= alu_carry_out;
                        r_eq     <= r_eq & alu_compare;
                    end
                    if (w_load) begin
                        r_alu_a        <= r_a[WORD_W-1:0];
                        r_alu_b        <= r_b[WORD_W-1:0];
                        r_a            <= r_a >> WORD_W;
                        r_b            <= r_b >> WORD_W;
                        r_alu_carry_in <= ~r_alu_mode & w_chain;
                        r_idx          <= r_idx + 1'b1;
                    end else begin
                        r_rsp_carry <= alu_carry_out;
                        r_rsp_equal <= r_eq & alu_compare;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_result   = r_result;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_equal    = r_rsp_equal;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_select   = r_alu_select;
    assign alu_mode     = r_alu_mode;
    assign alu_carry_in = r_alu_carry_in;

`ifdef ALU_WIDE_SEQ_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_carries;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_ops     <= '0;
            r_stat_carries <= '0;
        end else if (r_rsp_valid && rsp_ready) begin
            r_stat_ops <= r_stat_ops + 32'd1;
            if (r_rsp_carry)
                r_stat_carries <= r_stat_carries + 32'd1;
        end
    end

    assign stat_ops     = r_stat_ops;
    assign stat_carries = r_stat_carries;
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed bench for alu_wide_seq (WORDS=2) with a behavioural 16-bit ALU model
// supporting A (0000), A plus B (1001) and logic XOR (0110).
module tb_alu_wide_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_select;
    logic        req_mode;
    logic        req_carry_in;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_select;
    logic        alu_mode;
    logic        alu_carry_in;
    logic [15:0] alu_out;
    logic        alu_carry_out;
    logic        alu_compare;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_equal;

    int n_assert = 0;
    int n_fail   = 0;
    int lat;
    logic [3:0] cin_seen;

    alu_wide_seq #(.WORDS(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_select(req_select),
        .req_mode(req_mode), .req_carry_in(req_carry_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_equal(rsp_equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] sum17;
    always_comb begin
        sum17         = '0;
        alu_out       = alu_a;
        alu_carry_out = 1'b0;
        alu_compare   = (alu_a == alu_b);
        if (alu_mode) begin
            if (alu_select == 4'b0110) alu_out = alu_a ^ alu_b;
        end else if (alu_select == 4'b1001) begin
            sum17         = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_carry_in};
            alu_out       = sum17[15:0];
            alu_carry_out = sum17[16];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          input logic m, input logic c);
        req_a = a; req_b = b; req_select = sel; req_mode = m; req_carry_in = c;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 0;
        cin_seen = '0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
            if (lat <= 3) cin_seen[lat] = alu_carry_in;
        end
        chk("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_select = '0; req_mode = 1'b0; req_carry_in = 1'b0;
        step(); step();
        chk("rst_req_ready",  {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid",  {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
        chk("rst_rsp_carry",  {63'd0, rsp_carry}, 64'd0);
        chk("rst_rsp_equal",  {63'd0, rsp_equal}, 64'd0);
        chk("rst_alu_a",      {48'd0, alu_a}, 64'd0);
        chk("rst_alu_b",      {48'd0, alu_b}, 64'd0);
        chk("rst_alu_select", {60'd0, alu_select}, 64'd0);
        chk("rst_alu_mode",   {63'd0, alu_mode}, 64'd0);
        chk("rst_alu_cin",    {63'd0, alu_carry_in}, 64'd0);
        rst = 1'b1;
        step();

        // add with carry across the word boundary
        run_op(32'h0001FFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0);
        chk("add_latency", 64'(lat), 64'd3);
        chk("add_result",  {32'd0, rsp_result}, 64'h00020000);
        chk("add_carry",   {63'd0, rsp_carry}, 64'd0);
        chk("add_equal",   {63'd0, rsp_equal}, 64'd0);
        chk("add_busy",    {63'd0, req_ready}, 64'd0);
        chk("add_cin_w0",  {63'd0, cin_seen[1]}, 64'd0);
        chk("add_cin_w1",  {63'd0, cin_seen[2]}, 64'd1);
        release_rsp();
        chk("add_rel_ready", {63'd0, req_ready}, 64'd1);
        chk("add_rel_valid", {63'd0, rsp_valid}, 64'd0);

        // wide overflow
        run_op(32'hFFFFFFFF, 32'h00000001, 4'b1001, 1'b0, 1'b0);
        chk("ovf_latency", 64'(lat), 64'd3);
        chk("ovf_result",  {32'd0, rsp_result}, 64'h00000000);
        chk("ovf_carry",   {63'd0, rsp_carry}, 64'd1);
        chk("ovf_cin_w1",  {63'd0, cin_seen[2]}, 64'd1);
        release_rsp();

        // logic mode: carry_in forced low
        run_op(32'hF0F01234, 32'hFFFF1234, 4'b0110, 1'b1, 1'b1);
        chk("xor_result", {32'd0, rsp_result}, 64'h0F0F0000);
        chk("xor_carry",  {63'd0, rsp_carry}, 64'd0);
        chk("xor_equal",  {63'd0, rsp_equal}, 64'd0);
        chk("xor_cin_w0", {63'd0, cin_seen[1]}, 64'd0);
        chk("xor_cin_w1", {63'd0, cin_seen[2]}, 64'd0);
        chk("xor_mode",   {63'd0, alu_mode}, 64'd1);
        release_rsp();

        // equality flag
        run_op(32'hABCD5678, 32'hABCD5678, 4'b0000, 1'b0, 1'b0);
        chk("eq_equal",  {63'd0, rsp_equal}, 64'd1);
        chk("eq_result", {32'd0, rsp_result}, 64'hABCD5678);
        release_rsp();
        run_op(32'hABCD5679, 32'hABCD5678, 4'b0000, 1'b0, 1'b0);
        chk("neq_equal", {63'd0, rsp_equal}, 64'd0);
        release_rsp();

        // backpressure: response held, new request ignored
        run_op(32'h00001234, 32'h00001111, 4'b1001, 1'b0, 1'b0);
        req_a = 32'hFFFFFFFF; req_b = 32'h00000001; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid",  {63'd0, rsp_valid}, 64'd1);
            chk("bp_result", {32'd0, rsp_result}, 64'h00002345);
            chk("bp_carry",  {63'd0, rsp_carry}, 64'd0);
            chk("bp_ready",  {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        release_rsp();
        chk("bp_rel_ready", {63'd0, req_ready}, 64'd1);
        chk("bp_rel_valid", {63'd0, rsp_valid}, 64'd0);
        step();
        chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);

        // reset while word 1 is on the ALU
        req_a = 32'h0001FFFF; req_b = 32'h00000001; req_select = 4'b1001;
        req_mode = 1'b0; req_carry_in = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_ready",  {63'd0, req_ready}, 64'd1);
        chk("mid_rst_valid",  {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_result", {32'd0, rsp_result}, 64'd0);
        chk("mid_rst_cin",    {63'd0, alu_carry_in}, 64'd0);
        step(); step(); step();
        chk("mid_rst_quiet",  {63'd0, rsp_valid}, 64'd0);
        run_op(32'h00010002, 32'h00030004, 4'b1001, 1'b0, 1'b0);
        chk("post_rst_latency", 64'(lat), 64'd3);
        chk("post_rst_result",  {32'd0, rsp_result}, 64'h00040006);
        release_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
